// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three result FIFOs (ex0, ex1, ld) drained round-robin onto a registered CDB.
// Latency: a push sampled at edge E0 is broadcast on the CDB after edge E1 (2 edges, no bypass).
// Backpressure: *_nex_ava drops while a FIFO is full; rdy low freezes everything; flush empties all FIFOs.
module cdb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_wrong_stall,
   input  logic        ex0_flag,
   input  logic [31:0] ex0_val,
   input  logic [31:0] ex0_rob_id,
   input  logic [31:0] ex0_rel_pc,
   output logic        ex0_nex_ava,
   input  logic        ex1_flag,
   input  logic [31:0] ex1_val,
   input  logic [31:0] ex1_rob_id,
   input  logic [31:0] ex1_rel_pc,
   output logic        ex1_nex_ava,
   input  logic        ld_flag,
   input  logic [31:0] ld_val,
   input  logic [31:0] ld_rob_id,
   output logic        ld_nex_ava,
   output logic        cdb_flag,
   output logic [31:0] cdb_val,
   output logic [31:0] cdb_rob_id,
   output logic [31:0] cdb_rel_pc,
   output logic        cdb_is_ld
);

   localparam int          PW     = $clog2(DEPTH);
   localparam logic [PW:0] L_FULL = (PW + 1)'(DEPTH);

   // Per-source storage and pointers, source index 0 = ex0, 1 = ex1, 2 = ld.
   logic [31:0]   r_val [3][DEPTH];
   logic [31:0]   r_rob [3][DEPTH];
   logic [31:0]   r_pc  [3][DEPTH];
   logic [PW-1:0] r_head [3];
   logic [PW-1:0] r_tail [3];
   logic [PW:0]   r_cnt  [3];
   logic [1:0]    r_last;

   logic          r_cdb_flag;
   logic [31:0]   r_cdb_val;
   logic [31:0]   r_cdb_rob;
   logic [31:0]   r_cdb_pc;
   logic          r_cdb_is_ld;

   logic [2:0]    w_in_flag;
   logic [31:0]   w_in_val [3];
   logic [31:0]   w_in_rob [3];
   logic [31:0]   w_in_pc  [3];
   logic [2:0]    w_ava;
   logic [2:0]    w_nempty;
   logic [2:0]    w_push;
   logic [2:0]    w_pop;
   logic [1:0]    w_o0, w_o1, w_o2;
   logic [1:0]    w_win;
   logic          w_win_vld;
   logic [31:0]   w_sel_val;
   logic [31:0]   w_sel_rob;
   logic [31:0]   w_sel_pc;
   logic          w_flush;

   assign w_flush = rdy & jump_wrong_stall;

   // Gather the three producer interfaces into indexable form; loads carry no PC.
   always_comb begin
      w_in_flag   = {ld_flag, ex1_flag, ex0_flag};
      w_in_val[0] = ex0_val;
      w_in_val[1] = ex1_val;
      w_in_val[2] = ld_val;
      w_in_rob[0] = ex0_rob_id;
      w_in_rob[1] = ex1_rob_id;
      w_in_rob[2] = ld_rob_id;
      w_in_pc[0]  = ex0_rel_pc;
      w_in_pc[1]  = ex1_rel_pc;
      w_in_pc[2]  = '0;
   end

   // Occupancy flags and accepted pushes; availability ignores this cycle's pop.
   always_comb begin
      w_ava    = '0;
      w_nempty = '0;
      w_push   = '0;
      for (int i = 0; i < 3; i++) begin
         w_ava[i]    = (r_cnt[i] != L_FULL);
         w_nempty[i] = (r_cnt[i] != '0);
         w_push[i]   = rdy & ~jump_wrong_stall & w_in_flag[i] & w_ava[i];
      end
   end

   // Round-robin pick: try last+1, then last+2, then last itself.
   always_comb begin
      w_o0 = 2'd0;
      w_o1 = 2'd1;
      w_o2 = 2'd2;
      case (r_last)
         2'd0:    begin w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0; end
         2'd1:    begin w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1; end
         default: ;
      endcase
      w_win_vld = |w_nempty;
      w_win     = r_last;
      if (w_nempty[w_o0])      w_win = w_o0;
      else if (w_nempty[w_o1]) w_win = w_o1;
      else if (w_nempty[w_o2]) w_win = w_o2;
      w_pop = (rdy & ~jump_wrong_stall & w_win_vld) ? (3'b001 << w_win) : 3'b000;
   end

   // Head entry of the winning FIFO, ready to be registered onto the CDB.
   always_comb begin
      w_sel_val = '0;
      w_sel_rob = '0;
      w_sel_pc  = '0;
      case (w_win)
         2'd0:    begin w_sel_val = r_val[0][r_head[0]]; w_sel_rob = r_rob[0][r_head[0]]; w_sel_pc = r_pc[0][r_head[0]]; end
         2'd1:    begin w_sel_val = r_val[1][r_head[1]]; w_sel_rob = r_rob[1][r_head[1]]; w_sel_pc = r_pc[1][r_head[1]]; end
         default: begin w_sel_val = r_val[2][r_head[2]]; w_sel_rob = r_rob[2][r_head[2]]; w_sel_pc = '0; end
      endcase
   end

   // Entry storage: write at the tail on an accepted push (contents need no reset).
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (w_push[i]) begin
            r_val[i][r_tail[i]] <= w_in_val[i];
            r_rob[i][r_tail[i]] <= w_in_rob[i];
            r_pc[i][r_tail[i]]  <= w_in_pc[i];
         end
      end
   end

   // Pointers, counts and last grant; reset and flush both empty every FIFO.
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         for (int i = 0; i < 3; i++) begin
            r_head[i] <= '0;
            r_tail[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_last <= 2'd2;
      end else if (rdy) begin
         for (int i = 0; i < 3; i++) begin
            if (w_push[i]) r_tail[i] <= r_tail[i] + 1'b1;
            if (w_pop[i])  r_head[i] <= r_head[i] + 1'b1;
            r_cnt[i] <= r_cnt[i] + {{PW{1'b0}}, w_push[i]} - {{PW{1'b0}}, w_pop[i]};
         end
         if (w_win_vld) r_last <= w_win;
      end
   end

   // Registered CDB broadcast; fields hold when there is nothing to send.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cdb_flag  <= 1'b0;
         r_cdb_val   <= '0;
         r_cdb_rob   <= '0;
         r_cdb_pc    <= '0;
         r_cdb_is_ld <= 1'b0;
      end else if (rdy) begin
         if (jump_wrong_stall) begin
            r_cdb_flag <= 1'b0;
         end else if (w_win_vld) begin
            r_cdb_flag  <= 1'b1;
            r_cdb_val   <= w_sel_val;
            r_cdb_rob   <= w_sel_rob;
            r_cdb_pc    <= (w_win == 2'd2) ? 32'd0 : w_sel_pc;
            r_cdb_is_ld <= (w_win == 2'd2);
         end else begin
            r_cdb_flag <= 1'b0;
         end
      end
   end

   assign ex0_nex_ava = w_ava[0];
   assign ex1_nex_ava = w_ava[1];
   assign ld_nex_ava  = w_ava[2];
   assign cdb_flag    = r_cdb_flag;
   assign cdb_val     = r_cdb_val;
   assign cdb_rob_id  = r_cdb_rob;
   assign cdb_rel_pc  = r_cdb_pc;
   assign cdb_is_ld   = r_cdb_is_ld;

endmodule
